// File: rtl/seg7_scan_driver.sv
// Double-buffered, time-multiplexed driver for a 4-digit seven-segment display.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic        digits_valid,
    output logic        digits_ready,
    input  logic        display_en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int          CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]  AN_OFF   = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [CW-1:0] pre_cnt;
    logic [1:0]    scan_idx;
    logic [1:0]    scan_idx_nxt;
    logic [15:0]   shadow;
    logic [15:0]   disp;
    logic [15:0]   disp_nxt;
    logic          pending;
    logic          tick;
    logic          boundary;
    logic          accept;
    logic          commit;
    logic [3:0]    cur_digit;
    logic          blank;
    logic [6:0]    seg_hi;
    logic [3:0]    an_hi;
    logic [6:0]    seg_nxt;
    logic [3:0]    an_nxt;

    assign tick     = (pre_cnt == DIV_LAST);
    assign boundary = tick && (scan_idx == 2'd3);

    // Handshake: a transfer happens on a cycle with digits_valid && digits_ready.
    // Ready is simply !pending, so one value waits in the shadow until the next
    // frame boundary commits it; the producer holds its value meanwhile.
    assign digits_ready = !pending;
    assign accept       = digits_valid && digits_ready;
    assign commit       = boundary && pending;

    assign scan_idx_nxt = tick ? scan_idx + 2'd1 : scan_idx;
    assign disp_nxt     = commit ? shadow : disp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt    <= '0;
            scan_idx   <= 2'd0;
            shadow     <= 16'h0000;
            disp       <= 16'h0000;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pre_cnt    <= tick ? '0 : pre_cnt + CW'(1);
            scan_idx   <= scan_idx_nxt;
            disp       <= disp_nxt;
            frame_done <= boundary;
            if (commit) begin
                pending <= 1'b0;
            end else if (accept) begin
                shadow  <= digits_in;
                pending <= 1'b1;
            end
        end
    end

    // The output stage looks at next-cycle index and display contents so that
    // seg/an show the new slot exactly one cycle after tick.
    always_comb begin
        cur_digit = disp_nxt[3:0];
        case (scan_idx_nxt)
            2'd1:    cur_digit = disp_nxt[7:4];
            2'd2:    cur_digit = disp_nxt[11:8];
            2'd3:    cur_digit = disp_nxt[15:12];
            default: cur_digit = disp_nxt[3:0];
        endcase
    end

`ifdef SEG7_LZB_EN
    always_comb begin
        blank = 1'b0;
        case (scan_idx_nxt)
            2'd3:    blank = (disp_nxt[15:12] == 4'h0);
            2'd2:    blank = (disp_nxt[15:8] == 8'h00);
            2'd1:    blank = (disp_nxt[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_hi = 7'b1000000;
        case (cur_digit)
            4'd0:    seg_hi = 7'b0111111;
            4'd1:    seg_hi = 7'b0000110;
            4'd2:    seg_hi = 7'b1011011;
            4'd3:    seg_hi = 7'b1001111;
            4'd4:    seg_hi = 7'b1100110;
            4'd5:    seg_hi = 7'b1101101;
            4'd6:    seg_hi = 7'b1111101;
            4'd7:    seg_hi = 7'b0000111;
            4'd8:    seg_hi = 7'b1111111;
            4'd9:    seg_hi = 7'b1101111;
            default: seg_hi = 7'b1000000;
        endcase
    end

    assign an_hi = 4'b0001 << scan_idx_nxt;

    always_comb begin
        seg_nxt = SEG_OFF;
        an_nxt  = AN_OFF;
        if (display_en && !blank) begin
            seg_nxt = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            an_nxt  = SEG_ACTIVE_LOW ? ~an_hi : an_hi;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a frame-arithmetic model checked every
// cycle plus literal expectations taken from hand-decoded digit patterns.
module tb_seg7_scan_driver;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic        digits_valid = 1'b0;
    logic        display_en = 1'b1;
    logic        digits_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .digits_in    (digits_in),
        .digits_valid (digits_valid),
        .digits_ready (digits_ready),
        .display_en   (display_en),
        .seg          (seg),
        .an           (an),
        .frame_done   (frame_done)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    // Model: m_n counts clock edges since reset release; every 4*D edges is a
    // frame boundary and the visible slot is (m_n / D) % 4.
    int          m_n = 0;
    logic        m_pend = 1'b0;
    logic [15:0] m_shadow = 16'h0000;
    logic [15:0] m_disp = 16'h0000;
    logic        m_en = 1'b0;
    logic        m_fd = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n      = 0;
            m_pend   = 1'b0;
            m_shadow = 16'h0000;
            m_disp   = 16'h0000;
            m_en     = 1'b0;
            m_fd     = 1'b0;
        end else begin
            m_n  = m_n + 1;
            m_fd = (m_n % (4 * D) == 0);
            if (m_fd && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end else if (digits_valid && !m_pend) begin
                m_shadow = digits_in;
                m_pend   = 1'b1;
            end
            m_en = display_en;
        end
    end

    int          e_slot;
    logic [3:0]  e_digit;
    logic        e_blank;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;

    always @(negedge clk) begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
        if (m_n != 0) begin
            e_slot  = (m_n / D) % 4;
            e_digit = 4'(m_disp >> (4 * e_slot));
`ifdef SEG7_LZB_EN
            e_blank = (e_slot != 0) && ((m_disp >> (4 * e_slot)) == 16'h0000);
`else
            e_blank = 1'b0;
`endif
            if (m_en && !e_blank) begin
                e_an  = ~(4'b0001 << e_slot);
                e_seg = ~glyph(e_digit);
            end
        end
        check("model_an", 16'(an), 16'(e_an));
        check("model_seg", 16'(seg), 16'(e_seg));
        check("model_frame_done", 16'(frame_done), 16'(m_fd));
        check("model_ready", 16'(digits_ready), 16'(!m_pend));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            step();
            seen = frame_done;
        end
        check("frame_seen", 16'(seen), 16'd1);
    endtask

    task automatic load(input logic [15:0] v);
        step();
        digits_valid = 1'b1;
        digits_in    = v;
        step();
        digits_valid = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        check("rst_an", 16'(an), 16'h000F);
        check("rst_seg", 16'(seg), 16'h007F);
        check("rst_frame_done", 16'(frame_done), 16'h0000);
        rst = 1'b1;
        check("rst_ready", 16'(digits_ready), 16'h0001);

        // Basic load and scan
        load(16'h1234);
        check("ready_drop", 16'(digits_ready), 16'h0000);
        wait_frame();
        check("slot0_an", 16'(an), 16'h000E);
        check("slot0_seg_4", 16'(seg), 16'(7'b0011001));
        repeat (12) step();
        check("slot3_an", 16'(an), 16'h0007);
        check("slot3_seg_1", 16'(seg), 16'(7'b1111001));

        // Back-pressure: 0005 held valid while 9876 is pending
        step();
        digits_valid = 1'b1;
        digits_in    = 16'h9876;
        step();
        digits_in    = 16'h0005;
        wait_frame();
        check("bp_ready_back", 16'(digits_ready), 16'h0001);
        check("bp_seg_6", 16'(seg), 16'(7'b0000010));
        step();
        digits_valid = 1'b0;
        check("bp_ready_taken", 16'(digits_ready), 16'h0000);
        wait_frame();
        check("bp_seg_5", 16'(seg), 16'(7'b0010010));

        // Invalid BCD shows a dash
        load(16'h00A0);
        wait_frame();
        repeat (4) step();
        check("dash_an", 16'(an), 16'h000D);
        check("dash_seg", 16'(seg), 16'(7'b0111111));

        // Leading zeros
        load(16'h0007);
        wait_frame();
        check("lz_an0", 16'(an), 16'h000E);
        check("lz_seg7", 16'(seg), 16'(7'b1111000));
        repeat (4) step();
`ifdef SEG7_LZB_EN
        check("lz_an1_dark", 16'(an), 16'h000F);
        check("lz_seg1_dark", 16'(seg), 16'h007F);
`else
        check("lz_an1", 16'(an), 16'h000D);
        check("lz_seg1_zero", 16'(seg), 16'(7'b1000000));
`endif

        // display_en dropped mid-frame
        repeat (2) step();
        display_en = 1'b0;
        step();
        check("en_an_off", 16'(an), 16'h000F);
        check("en_seg_off", 16'(seg), 16'h007F);
        wait_frame();
        display_en = 1'b1;
        step();

        // Reset mid-frame with a pending value
        load(16'h4321);
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("mrst_an", 16'(an), 16'h000F);
        check("mrst_seg", 16'(seg), 16'h007F);
        check("mrst_frame_done", 16'(frame_done), 16'h0000);
        check("mrst_ready", 16'(digits_ready), 16'h0001);
        repeat (2) step();
        rst = 1'b1;
        check("mrst_ready_after", 16'(digits_ready), 16'h0001);
        wait_frame();
        wait_frame();
        check("mrst_an0", 16'(an), 16'h000E);
        check("mrst_seg0_zero", 16'(seg), 16'(7'b1000000));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
